spi_slave_regif: RTL and testbench

- SPI target (slave) endpoint. It is the far end of the SPI master link: it receives spi_cs/spi_dclk/spi_dout from a master and drives the master's data-in line.
- The SPI pins are oversampled in the system clock domain.
- Frames are decoded as a command byte followed by data bytes. Each data byte becomes one access on a simple 8-bit local register bus, with the address auto-incrementing.
- Used as a debug/config port and as the loopback partner for SPI-master verification.

---
 rtl/spi_slv_pkg.sv | 28 ++
 rtl/spi_slv_sync.sv | 33 +++
 rtl/spi_slave_regif.sv | 218 +++++++++++++++++++++
 tb/tb_spi_slave_regif.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slv_pkg.sv
// Shared types and constants for the SPI target register-interface block.
// Holds the frame state encoding, command/byte layout and status byte fields.
package spi_slv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    localparam int BYTE_W     = 8;
    localparam int CMD_RW_BIT = 7;

    localparam int STAT_ERR_BIT = 7;
    localparam int STAT_CNT_LSB = 0;
    localparam int STAT_CNT_W   = 4;

    function automatic logic [BYTE_W-1:0] status_byte(input logic err,
                                                      input logic [STAT_CNT_W-1:0] cnt);
        logic [BYTE_W-1:0] s;
        s = '0;
        s[STAT_ERR_BIT] = err;
        s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
        return s;
    endfunction

endpackage

// File: rtl/spi_slv_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin plus a rise/fall
// pulse detector on the synchronized level.
module spi_slv_sync
    import spi_slv_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
            prev  <= chain[STAGES-1];
        end
    end

    assign q    = chain[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_regif.sv
// SPI target that turns command+data frames into accesses on an 8-bit register bus.
// Optional status byte during the command phase: define SPI_SLV_STATUS_EN.
module spi_slave_regif
    import spi_slv_pkg::*;
#(
    parameter int AW          = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          spi_cs_n_i,
    input  logic          spi_sclk_i,
    input  logic          spi_mosi_i,
    output logic          spi_miso_o,
    output logic          spi_miso_oe,
    output logic          reg_req,
    output logic          reg_we,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    input  logic [7:0]    reg_rdata,
    output logic          frame_active,
    output logic          frame_err
);

    state_t state, state_next;

    logic                   cs_q, cs_rise, cs_fall;
    logic                   sclk_level_unused, sclk_rise, sclk_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic                   mosi_s;

    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] rx_shift, rx_byte, tx_shift;
    logic [AW-1:0]     addr;
    logic              rd_pending, armed, active, byte_done, tx_shift_en;

    spi_slv_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (spi_cs_n_i),
        .q    (cs_q),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    spi_slv_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (spi_sclk_i),
        .q    (sclk_level_unused),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // MOSI goes through the same depth as SCLK so it lines up with the rise pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_chain <= '0;
        end else begin
            mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], spi_mosi_i};
        end
    end

    assign mosi_s  = mosi_chain[SYNC_STAGES-1];
    assign active  = (state != IDLE);
    assign rx_byte = {rx_shift[BYTE_W-2:0], mosi_s};

    // CS rising always wins over an SCLK edge seen in the same clock.
    assign byte_done = active && sclk_rise && !cs_rise && (bit_cnt == 3'd7);

    // Falls only shift mid-byte, so the MSB survives the fall that trails the
    // last rise (mode 0) and the leading fall of a byte (mode 3).
    assign tx_shift_en = active && sclk_fall && !cs_rise && (bit_cnt != 3'd0);

    // A frame is only reported once CS has been seen high since reset.
    assign frame_active = armed & ~cs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (cs_fall) state_next = CMD;
            CMD: begin
                if (cs_rise) begin
                    state_next = IDLE;
                end else if (byte_done) begin
                    state_next = rx_byte[CMD_RW_BIT] ? RDATA : WDATA;
                end
            end
            WDATA: if (cs_rise) state_next = IDLE;
            RDATA: if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        spi_miso_o  = 1'b0;
        spi_miso_oe = 1'b0;
        case (state)
            CMD: begin
                spi_miso_oe = frame_active;
`ifdef SPI_SLV_STATUS_EN
                spi_miso_o  = tx_shift[BYTE_W-1];
`endif
            end
            WDATA: spi_miso_oe = frame_active;
            RDATA: begin
                spi_miso_oe = frame_active;
                spi_miso_o  = tx_shift[BYTE_W-1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            rx_shift   <= '0;
            addr       <= '0;
            reg_req    <= 1'b0;
            reg_we     <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            rd_pending <= 1'b0;
            frame_err  <= 1'b0;
            armed      <= 1'b0;
        end else begin
            reg_req    <= 1'b0;
            reg_we     <= 1'b0;
            frame_err  <= 1'b0;
            rd_pending <= reg_req & ~reg_we;
            if (cs_q) armed <= 1'b1;

            if (cs_rise) begin
                frame_err <= active && (bit_cnt != 3'd0);
                bit_cnt   <= '0;
            end else if (state == IDLE) begin
                if (cs_fall) begin
                    bit_cnt  <= '0;
                    rx_shift <= '0;
                end
            end else if (sclk_rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= rx_byte;
                if (byte_done) begin
                    case (state)
                        CMD: begin
                            if (rx_byte[CMD_RW_BIT]) begin
                                reg_req  <= 1'b1;
                                reg_addr <= rx_byte[AW-1:0];
                                addr     <= rx_byte[AW-1:0] + AW'(1);
                            end else begin
                                addr     <= rx_byte[AW-1:0];
                            end
                        end
                        WDATA: begin
                            reg_req   <= 1'b1;
                            reg_we    <= 1'b1;
                            reg_addr  <= addr;
                            reg_wdata <= rx_byte;
                            addr      <= addr + AW'(1);
                        end
                        RDATA: begin
                            reg_req  <= 1'b1;
                            reg_addr <= addr;
                            addr     <= addr + AW'(1);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef SPI_SLV_STATUS_EN
    logic                  err_sticky;
    logic [STAT_CNT_W-1:0] wr_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky <= 1'b0;
            wr_count   <= '0;
        end else begin
            if (frame_err) begin
                err_sticky <= 1'b1;
            end else if (state == CMD && byte_done) begin
                err_sticky <= 1'b0;
            end
            if (reg_req && reg_we) wr_count <= wr_count + STAT_CNT_W'(1);
        end
    end
`endif

    // A read reload takes priority over a shift landing in the same clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_shift <= '0;
        end else if (state == IDLE && cs_fall) begin
`ifdef SPI_SLV_STATUS_EN
            tx_shift <= status_byte(err_sticky, wr_count);
`else
            tx_shift <= '0;
`endif
        end else if (rd_pending) begin
            tx_shift <= reg_rdata;
        end else if (tx_shift_en) begin
            tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_spi_slave_regif.sv
// Randomized self-checking bench for spi_slave_regif: a frame-level model predicts
// register accesses, MISO bytes, status byte and frame errors.
module tb_spi_slave_regif;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_cs_n_i, spi_sclk_i, spi_mosi_i;
    logic       spi_miso_o, spi_miso_oe;
    logic       reg_req, reg_we;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata, reg_rdata;
    logic       frame_active, frame_err;

    always #5 clk = ~clk;

    spi_slave_regif #(.AW(7), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_cs_n_i   (spi_cs_n_i),
        .spi_sclk_i   (spi_sclk_i),
        .spi_mosi_i   (spi_mosi_i),
        .spi_miso_o   (spi_miso_o),
        .spi_miso_oe  (spi_miso_oe),
        .reg_req      (reg_req),
        .reg_we       (reg_we),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .frame_active (frame_active),
        .frame_err    (frame_err)
    );

    typedef struct packed {
        logic       we;
        logic [6:0] addr;
        logic [7:0] data;
    } acc_t;

    acc_t       exp_q[$];
    acc_t       cmp_e;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         err_seen = 0;
    int         last_err_delta;
    bit         cpol;
    int         hp;
    logic [7:0] regs [128];
    logic [7:0] mdl_regs [128];
    bit         mdl_sticky;
    logic [3:0] mdl_wrc;
    logic [7:0] wdat [4];
    logic [7:0] rx_bytes [5];

    function automatic logic [7:0] init_val(input int i);
        if (i == 32) return 8'h5A;
        if (i == 33) return 8'hC3;
        return 8'((i * 37 + 11) & 255);
    endfunction

    // Register file seen by the DUT; read data is returned one clock after the strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) regs[i] <= init_val(i);
            reg_rdata <= 8'h00;
        end else if (reg_req) begin
            if (reg_we) regs[reg_addr] <= reg_wdata;
            else        reg_rdata      <= regs[reg_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) err_seen++;
            if (reg_req) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_req", {reg_we, reg_addr, reg_wdata}, 32'h0);
                end else begin
                    cmp_e = exp_q.pop_front();
                    checkOutput("req_we", reg_we, cmp_e.we);
                    checkOutput("req_addr", reg_addr, cmp_e.addr);
                    if (cmp_e.we) checkOutput("req_wdata", reg_wdata, cmp_e.data);
                end
            end
        end
    end

    task automatic model_init();
        for (int i = 0; i < 128; i++) mdl_regs[i] = init_val(i);
        mdl_sticky = 1'b0;
        mdl_wrc    = 4'd0;
        exp_q.delete();
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_start();
        spi_sclk_i = cpol;
        spi_mosi_i = 1'b0;
        wait_clks(4);
        spi_cs_n_i = 1'b0;
        wait_clks(hp);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (cpol) spi_sclk_i = 1'b0;
            spi_mosi_i = b[7-i];
            wait_clks(hp);
            r = {r[6:0], spi_miso_o};
            spi_sclk_i = 1'b1;
            wait_clks(hp);
            if (!cpol) spi_sclk_i = 1'b0;
        end
    endtask

    task automatic spi_end();
        wait_clks(hp);
        spi_cs_n_i = 1'b1;
        wait_clks(10);
    endtask

    // One full frame: predict everything from the frame description, then drive it.
    task automatic applyStimulus(input logic rw, input logic [6:0] a, input int ndata, input int part);
        logic [7:0] exp_stat, r;
        logic [7:0] rd_exp [4];
        logic [6:0] ai;
        acc_t       e;
        int         e0;
`ifdef SPI_SLV_STATUS_EN
        exp_stat = {mdl_sticky, 3'b000, mdl_wrc};
`else
        exp_stat = 8'h00;
`endif
        mdl_sticky = 1'b0;
        for (int i = 0; i <= ndata; i++) begin
            ai = a + 7'(i);
            if (rw) begin
                if (i < ndata) rd_exp[i] = mdl_regs[ai];
                e.we = 1'b0; e.addr = ai; e.data = 8'h00;
                exp_q.push_back(e);
            end else if (i < ndata) begin
                e.we = 1'b1; e.addr = ai; e.data = wdat[i];
                exp_q.push_back(e);
                mdl_regs[ai] = wdat[i];
                mdl_wrc = mdl_wrc + 4'd1;
            end
        end
        if (part != 0) mdl_sticky = 1'b1;

        e0 = err_seen;
        spi_start();
        checkOutput("frame_active", frame_active, 1);
        checkOutput("miso_oe", spi_miso_oe, 1);
        spi_bits({rw, a}, 8, r);
        rx_bytes[0] = r;
        checkOutput("status_byte", r, exp_stat);
        for (int i = 0; i < ndata; i++) begin
            spi_bits(wdat[i], 8, r);
            rx_bytes[i+1] = r;
            if (rw) checkOutput("miso_data", r, rd_exp[i]);
        end
        if (part != 0) spi_bits(8'($urandom), part, r);
        spi_end();
        last_err_delta = err_seen - e0;
        checkOutput("frame_err_count", last_err_delta, (part != 0) ? 1 : 0);
        checkOutput("pending_accesses", exp_q.size(), 0);
        checkOutput("idle_oe", spi_miso_oe, 0);
        checkOutput("idle_miso", spi_miso_o, 0);
        checkOutput("idle_active", frame_active, 0);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_req"}, reg_req, 0);
        checkOutput({tag, "_we"}, reg_we, 0);
        checkOutput({tag, "_addr"}, reg_addr, 0);
        checkOutput({tag, "_wdata"}, reg_wdata, 0);
        checkOutput({tag, "_miso"}, spi_miso_o, 0);
        checkOutput({tag, "_oe"}, spi_miso_oe, 0);
        checkOutput({tag, "_active"}, frame_active, 0);
        checkOutput({tag, "_err"}, frame_err, 0);
    endtask

    initial begin
        logic [7:0] m0_b1, m0_b2, r;
        acc_t       e;
        int         e0;

        rst = 1'b1; spi_cs_n_i = 1'b1; spi_sclk_i = 1'b0; spi_mosi_i = 1'b0;
        cpol = 1'b0; hp = 5;
        model_init();
        wait_clks(3);
        check_all_zero("reset");
        rst = 1'b0;
        wait_clks(8);

        $display("[TB] write burst");
        wdat[0] = 8'hA5; wdat[1] = 8'h3C;
        applyStimulus(1'b0, 7'h12, 2, 0);
        checkOutput("wr_burst_0x12", regs[7'h12], 8'hA5);
        checkOutput("wr_burst_0x13", regs[7'h13], 8'h3C);

        $display("[TB] read burst");
        applyStimulus(1'b1, 7'h20, 2, 0);
        checkOutput("rd_burst_b0", rx_bytes[1], 8'h5A);
        checkOutput("rd_burst_b1", rx_bytes[2], 8'hC3);

        $display("[TB] address wrap");
        wdat[0] = 8'h11; wdat[1] = 8'h22;
        applyStimulus(1'b0, 7'h7F, 2, 0);
        checkOutput("wrap_0x7f", regs[7'h7F], 8'h11);
        checkOutput("wrap_0x00", regs[7'h00], 8'h22);

        $display("[TB] partial byte");
        applyStimulus(1'b0, 7'h50, 0, 5);
        checkOutput("partial_err_pulses", last_err_delta, 1);
        wdat[0] = 8'h99;
        applyStimulus(1'b0, 7'h51, 1, 0);
`ifdef SPI_SLV_STATUS_EN
        checkOutput("status_after_err", rx_bytes[0], 8'h84);
`else
        checkOutput("status_after_err", rx_bytes[0], 8'h00);
`endif
        checkOutput("after_partial_0x51", regs[7'h51], 8'h99);

        $display("[TB] mode 0 vs mode 3 read");
        applyStimulus(1'b1, 7'h05, 2, 0);
        m0_b1 = rx_bytes[1]; m0_b2 = rx_bytes[2];
        cpol = 1'b1; hp = 4;
        applyStimulus(1'b1, 7'h05, 2, 0);
        checkOutput("mode3_b0", rx_bytes[1], m0_b1);
        checkOutput("mode3_b1", rx_bytes[2], m0_b2);
        cpol = 1'b0; hp = 5;

        $display("[TB] reset mid read");
        e.we = 1'b0; e.addr = 7'h30; e.data = 8'h00;
        exp_q.push_back(e);
        spi_start();
        spi_bits(8'hB0, 8, r);
        spi_bits(8'h00, 3, r);
        checkOutput("pre_reset_reads", exp_q.size(), 0);
        rst = 1'b1;
        #2;
        check_all_zero("mid_reset");
        wait_clks(1);
        rst = 1'b0;
        model_init();
        e0 = err_seen;
        spi_bits(8'h12, 8, r);
        spi_bits(8'hEE, 8, r);
        checkOutput("post_reset_active", frame_active, 0);
        checkOutput("post_reset_oe", spi_miso_oe, 0);
        spi_end();
        checkOutput("post_reset_err", err_seen - e0, 0);
        applyStimulus(1'b1, 7'h40, 1, 0);
        checkOutput("post_reset_status", rx_bytes[0], 8'h00);

        $display("[TB] random frames");
        for (int f = 0; f < 30; f++) begin
            cpol = 1'($urandom_range(0, 1));
            hp   = $urandom_range(4, 7);
            for (int i = 0; i < 4; i++) wdat[i] = 8'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), 7'($urandom), $urandom_range(0, 3),
                          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
